// File: rtl/apb_mem_slave_pkg.sv
// apb_mem_slave_pkg
// Shared types and constants for the APB memory slave.
//   state_t  : transfer FSM state (IDLE, ACCESS)
//   WCNT_W   : width of the wait-state counter (WAIT_STATES range 0..15)
//   CNT_W    : width of the completed-transfer counters
//   sat_inc  : saturating increment used by the transfer counters
package apb_mem_slave_pkg;

    localparam int WCNT_W = 4;
    localparam int CNT_W  = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Increment by one, sticking at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// apb_mem_slave_if
// APB bus bundle between a requester and the memory slave.
//   master modport : drives psel/penable/pwrite/paddr/pwdata, receives prdata/pready/pslverr
//   slave  modport : the mirror image
interface apb_mem_slave_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_mem_slave_ram.sv
// apb_mem_slave_ram
// MEM_DEPTH x DATA_WIDTH storage, not reset.
//   clk   : write clock (rising edge)
//   we    : write enable, waddr/wdata committed on the clock edge
//   raddr : read index, rdata follows it combinationally so the
//           controller can capture it on the same edge it samples SETUP
module apb_mem_slave_ram #(
    parameter  int MEM_DEPTH  = 256,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    // Single synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave
// APB word-addressed memory slave with programmable wait states and
// saturating completed-transfer counters.
//   pclk, preset : clock (rising edge) and asynchronous active-high reset
//   apb          : APB slave bus (psel/penable/pwrite/paddr/pwdata in,
//                  prdata/pready/pslverr out, all outputs registered)
//   cnt_clr      : synchronous clear of wr_cnt/rd_cnt, wins over increment
//   wr_cnt/rd_cnt: good completed writes/reads, saturating at 16'hFFFF
// Build option: define APB_MEM_SLAVE_PSLVERR_EN to answer addresses with any
// bit set above log2(MEM_DEPTH) with pslverr=1 (no write, prdata=0).
// Without it pslverr stays 0 and the address wraps modulo MEM_DEPTH.
module apb_mem_slave
    import apb_mem_slave_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 256,
    parameter int WAIT_STATES    = 1
) (
    input  logic              pclk,
    input  logic              preset,
    apb_mem_slave_if.slave    apb,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    localparam int                IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_LD  = WCNT_W'(WAIT_STATES);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

    state_t                    state_r;
    logic [WCNT_W-1:0]         wcnt_r;
    logic                      pready_r;
    logic                      pslverr_r;
    logic [APB_DATA_WIDTH-1:0] prdata_r;
    logic                      cap_write_r;
    logic                      cap_err_r;
    logic [IDX_W-1:0]          cap_idx_r;
    logic [APB_DATA_WIDTH-1:0] cap_wdata_r;
    logic [CNT_W-1:0]          wr_cnt_r;
    logic [CNT_W-1:0]          rd_cnt_r;

    logic [IDX_W-1:0]          idx_s;
    logic                      range_err_s;
    logic [APB_DATA_WIDTH-1:0] ram_rdata_s;
    logic                      done_s;
    logic                      done_ok_s;
    logic                      ram_we_s;

    assign idx_s = apb.paddr[IDX_W-1:0];

`ifdef APB_MEM_SLAVE_PSLVERR_EN
    assign range_err_s = |apb.paddr[APB_ADDR_WIDTH-1:IDX_W];
`else
    // Upper address bits are don't-care when the range check is off.
    logic unused_addr_s;
    assign unused_addr_s = ^apb.paddr[APB_ADDR_WIDTH-1:IDX_W];
    assign range_err_s   = 1'b0;
`endif

    // pready_r is only ever set while in ACCESS with wcnt_r==0; psel must
    // still be high on that edge, otherwise the transfer counts as aborted.
    assign done_s    = (state_r == ACCESS) && pready_r && apb.psel;
    assign done_ok_s = done_s && !cap_err_r;
    assign ram_we_s  = done_ok_s && cap_write_r;

    apb_mem_slave_ram #(
        .MEM_DEPTH  (MEM_DEPTH),
        .DATA_WIDTH (APB_DATA_WIDTH)
    ) u_ram (
        .clk   (pclk),
        .we    (ram_we_s),
        .waddr (cap_idx_r),
        .wdata (cap_wdata_r),
        .raddr (idx_s),
        .rdata (ram_rdata_s)
    );

    // Transfer FSM: SETUP capture, wait-state countdown, completion/abort.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_r     <= IDLE;
            wcnt_r      <= '0;
            pready_r    <= 1'b0;
            pslverr_r   <= 1'b0;
            prdata_r    <= '0;
            cap_write_r <= 1'b0;
            cap_err_r   <= 1'b0;
            cap_idx_r   <= '0;
            cap_wdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    // penable=1 without a prior SETUP is ignored here.
                    if (apb.psel && !apb.penable) begin
                        state_r     <= ACCESS;
                        wcnt_r      <= WAIT_LD;
                        pready_r    <= (WAIT_LD == '0);
                        pslverr_r   <= (WAIT_LD == '0) && range_err_s;
                        cap_write_r <= apb.pwrite;
                        cap_err_r   <= range_err_s;
                        cap_idx_r   <= idx_s;
                        cap_wdata_r <= apb.pwdata;
                        // Read data is fetched at SETUP; writes/errors return 0.
                        prdata_r    <= (!apb.pwrite && !range_err_s) ? ram_rdata_s : '0;
                    end else begin
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (!apb.psel) begin
                        state_r   <= IDLE;
                        wcnt_r    <= '0;
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                    end else if (pready_r) begin
                        // A SETUP overlapping this cycle is picked up from IDLE next cycle.
                        state_r   <= IDLE;
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                    end else begin
                        wcnt_r    <= wcnt_r - WCNT_ONE;
                        pready_r  <= (wcnt_r == WCNT_ONE);
                        pslverr_r <= (wcnt_r == WCNT_ONE) && cap_err_r;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    wcnt_r    <= '0;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                end
            endcase
        end
    end

    // Completed good-transfer counters; clear beats a same-cycle increment.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_cnt_r <= '0;
            rd_cnt_r <= '0;
        end else if (cnt_clr) begin
            wr_cnt_r <= '0;
            rd_cnt_r <= '0;
        end else if (done_ok_s) begin
            if (cap_write_r) begin
                wr_cnt_r <= sat_inc(wr_cnt_r);
            end else begin
                rd_cnt_r <= sat_inc(rd_cnt_r);
            end
        end
    end

    assign apb.prdata  = prdata_r;
    assign apb.pready  = pready_r;
    assign apb.pslverr = pslverr_r;
    assign wr_cnt      = wr_cnt_r;
    assign rd_cnt      = rd_cnt_r;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave
// Directed bench for apb_mem_slave. Two instances share the stimulus:
// dut_ws1 (WAIT_STATES=1) and dut_ws0 (WAIT_STATES=0); dsel picks which one
// sees psel. Expected read data / pslverr go into a scoreboard queue at
// SETUP and are popped when pready is seen. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_apb_mem_slave;
    import apb_mem_slave_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        pclk;
    logic        preset;
    logic        cnt_clr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    int          dsel;
    logic [15:0] wr_cnt1, rd_cnt1, wr_cnt0, rd_cnt0;

    int          n_checks;
    int          n_errors;
    exp_t        exp_q[$];
    logic [31:0] mdl_mem [2][256];
    int          mdl_wr [2];
    int          mdl_rd [2];

    apb_mem_slave_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus1 ();
    apb_mem_slave_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus0 ();

    assign bus1.psel    = psel && (dsel == 1);
    assign bus1.penable = penable;
    assign bus1.pwrite  = pwrite;
    assign bus1.paddr   = paddr;
    assign bus1.pwdata  = pwdata;
    assign bus0.psel    = psel && (dsel == 0);
    assign bus0.penable = penable;
    assign bus0.pwrite  = pwrite;
    assign bus0.paddr   = paddr;
    assign bus0.pwdata  = pwdata;

    apb_mem_slave #(.WAIT_STATES(1)) dut_ws1 (
        .pclk    (pclk),
        .preset  (preset),
        .apb     (bus1.slave),
        .cnt_clr (cnt_clr),
        .wr_cnt  (wr_cnt1),
        .rd_cnt  (rd_cnt1)
    );

    apb_mem_slave #(.WAIT_STATES(0)) dut_ws0 (
        .pclk    (pclk),
        .preset  (preset),
        .apb     (bus0.slave),
        .cnt_clr (cnt_clr),
        .wr_cnt  (wr_cnt0),
        .rd_cnt  (rd_cnt0)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic rdy(input int d);
        return (d == 1) ? bus1.pready : bus0.pready;
    endfunction

    function automatic logic serr(input int d);
        return (d == 1) ? bus1.pslverr : bus0.pslverr;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 1) ? bus1.prdata : bus0.prdata;
    endfunction

    function automatic logic [31:0] wcnt(input int d);
        return (d == 1) ? {16'd0, wr_cnt1} : {16'd0, wr_cnt0};
    endfunction

    function automatic logic [31:0] rcnt(input int d);
        return (d == 1) ? {16'd0, rd_cnt1} : {16'd0, rd_cnt0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete APB transfer starting at a falling edge. exp_acc is the
    // number of ACCESS cycles up to and including the one with pready=1.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit clr, input int exp_acc);
        exp_t e;
        int   acc;
        bit   err;
        int   idx;
        idx = int'(addr[7:0]);
`ifdef APB_MEM_SLAVE_PSLVERR_EN
        err = (addr[31:8] != 24'd0);
`else
        err = 1'b0;
`endif
        e.err  = err;
        e.data = (wr || err) ? 32'd0 : mdl_mem[d][idx];
        exp_q.push_back(e);
        dsel    = d;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge pclk);
        penable = 1'b1;
        acc     = 1;
        while (!rdy(d) && acc < 20) begin
            @(negedge pclk);
            acc++;
        end
        check("access_cycles", acc, exp_acc);
        e = exp_q.pop_front();
        check("prdata", rdat(d), e.data);
        check("pslverr", {31'd0, serr(d)}, {31'd0, e.err});
        if (clr) cnt_clr = 1'b1;
        @(negedge pclk);
        cnt_clr = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        if (clr) begin
            mdl_wr[0] = 0; mdl_wr[1] = 0;
            mdl_rd[0] = 0; mdl_rd[1] = 0;
        end else if (!err) begin
            if (wr) mdl_wr[d] = (mdl_wr[d] == 32'hFFFF) ? mdl_wr[d] : mdl_wr[d] + 1;
            else    mdl_rd[d] = (mdl_rd[d] == 32'hFFFF) ? mdl_rd[d] : mdl_rd[d] + 1;
        end
        if (!err && wr) mdl_mem[d][idx] = data;
        check("wr_cnt", wcnt(d), mdl_wr[d]);
        check("rd_cnt", rcnt(d), mdl_rd[d]);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mdl_wr   = '{0, 0};
        mdl_rd   = '{0, 0};
        preset   = 1'b1;
        cnt_clr  = 1'b0;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = 32'd0;
        pwdata   = 32'd0;
        dsel     = 1;

        // Reset state
        repeat (3) @(negedge pclk);
        check("rst_pready", {31'd0, bus1.pready}, 32'd0);
        check("rst_pslverr", {31'd0, bus1.pslverr}, 32'd0);
        check("rst_prdata", bus1.prdata, 32'd0);
        check("rst_wr_cnt", wcnt(1), 32'd0);
        check("rst_rd_cnt", rcnt(1), 32'd0);
        check("rst_pready0", {31'd0, bus0.pready}, 32'd0);
        preset = 1'b0;
        @(negedge pclk);

        // WAIT_STATES=1: write then read addr 3, pready on 2nd ACCESS cycle
        xfer(1, 1'b1, 32'd3, 32'hDEAD_BEEF, 1'b0, 2);
        xfer(1, 1'b0, 32'd3, 32'd0, 1'b0, 2);

        // WAIT_STATES=0: back-to-back writes 0..7 then reads, 2 cycles each
        for (int i = 0; i < 8; i++) xfer(0, 1'b1, i, i * 32'h11, 1'b0, 1);
        for (int i = 0; i < 8; i++) xfer(0, 1'b0, i, 32'd0, 1'b0, 1);

        // Out-of-range address: error response or wrap to word 0
        xfer(0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1'b0, 1);
        xfer(0, 1'b0, 32'd0, 32'd0, 1'b0, 1);

        // Abort: psel drops during the wait cycle of a write to addr 9
        xfer(1, 1'b1, 32'd9, 32'h0000_0099, 1'b0, 2);
        dsel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'd9; pwdata = 32'h1234_5678;
        @(negedge pclk);
        check("abort_wait_pready", {31'd0, bus1.pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("abort_state", 32'(dut_ws1.state_r), 32'(IDLE));
        check("abort_pready", {31'd0, bus1.pready}, 32'd0);
        check("abort_wr_cnt", wcnt(1), mdl_wr[1]);
        xfer(1, 1'b0, 32'd9, 32'd0, 1'b0, 2);

        // penable=1 while IDLE is not a SETUP
        dsel = 1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'd9;
        repeat (2) @(negedge pclk);
        check("idle_penable_pready", {31'd0, bus1.pready}, 32'd0);
        check("idle_penable_state", 32'(dut_ws1.state_r), 32'(IDLE));
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);

        // Reset asserted in the completing cycle of a write to addr 5
        xfer(1, 1'b1, 32'd5, 32'h0000_0055, 1'b0, 2);
        dsel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'd5; pwdata = 32'hAAAA_AAAA;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        #1 preset = 1'b1;
        #1;
        check("midrst_pready", {31'd0, bus1.pready}, 32'd0);
        check("midrst_wr_cnt", wcnt(1), 32'd0);
        check("midrst_rd_cnt", rcnt(1), 32'd0);
        mdl_wr = '{0, 0};
        mdl_rd = '{0, 0};
        @(negedge pclk);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        xfer(1, 1'b0, 32'd5, 32'd0, 1'b0, 2);

        // Saturation from a preloaded counter, then clear beats increment
        force dut_ws1.wr_cnt_r = 16'hFFFE;
        @(negedge pclk);
        release dut_ws1.wr_cnt_r;
        mdl_wr[1] = 32'hFFFE;
        @(negedge pclk);
        check("sat_preload", wcnt(1), 32'h0000_FFFE);
        xfer(1, 1'b1, 32'd20, 32'h0000_0001, 1'b0, 2);
        xfer(1, 1'b1, 32'd21, 32'h0000_0002, 1'b0, 2);
        check("sat_hold", wcnt(1), 32'h0000_FFFF);
        xfer(1, 1'b1, 32'd22, 32'h0000_0003, 1'b1, 2);
        check("clr_priority", wcnt(1), 32'd0);

        repeat (2) @(negedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
